// File: rtl/philv_pkg.sv
// Shared definitions for the philv instruction-fetch slice.
// Contents:
//   fetch_state_e : fetch FSM state encoding (IDLE, RUN, FLUSH)
//   PC_STEP       : byte increment between consecutive fetch addresses
package philv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_e;

    localparam int unsigned PC_STEP = 32'd4;

endpackage

// File: rtl/philv_fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory, execute (redirect)
// and decode.
// Signals:
//   imem_req_valid/ready/addr : fetch request handshake towards memory
//   imem_rsp_valid/data       : in-order memory responses, always accepted
//   redirect_valid/pc         : branch/jump target from execute
//   instr_valid/ready/data/pc : instruction handshake towards decode
// Modports: master = fetch unit side, slave = environment side.
interface philv_fetch_unit_if #(
    parameter int XLEN = 32
) ();
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] instr_data;
    logic [XLEN-1:0] instr_pc;

    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/philv_fifo.sv
// Prefetch buffer: DEPTH-entry circular FIFO with a registered storage array.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   flush             : synchronous empty; wins over push and pop
//   push, push_data   : write one entry (ignored when full)
//   pop               : drop the head entry (ignored when empty)
//   pop_data          : current head entry
//   empty, count      : occupancy status
module philv_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Qualify push/pop against occupancy; a flush suppresses both.
    always_comb begin
        push_ok_s = 1'b0;
        pop_ok_s  = 1'b0;
        if (flush) begin
            push_ok_s = 1'b0;
            pop_ok_s  = 1'b0;
        end else begin
            push_ok_s = push && (count_r != CW'(DEPTH));
            pop_ok_s  = pop && (count_r != {CW{1'b0}});
        end
    end

    // Storage, pointers and occupancy counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign pop_data = mem_r[rd_ptr_r];
    assign empty    = (count_r == {CW{1'b0}});
    assign count    = count_r;

endmodule

// File: rtl/philv_fetch_unit.sv
// Instruction fetch unit: issues sequential fetch requests, tracks requests
// in flight, buffers in-order responses with their PCs and hands them to
// decode. A redirect empties the buffer and discards the responses of every
// request still in flight before the new stream is accepted.
// Ports:
//   clk, rstb : clock, asynchronous active-low reset
//   bus       : philv_fetch_unit_if.master (memory, redirect, decode)
//   perf_fetched, perf_stall : only with PHILV_FETCH_PERF_EN defined;
//              saturating counts of accepted requests and of RUN/FLUSH
//              cycles without a valid instruction.
module philv_fetch_unit
    import philv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rstb,
    philv_fetch_unit_if.master      bus
`ifdef PHILV_FETCH_PERF_EN
    ,
    output logic [31:0]             perf_fetched,
    output logic [31:0]             perf_stall
`endif
);
    localparam int              CW   = $clog2(DEPTH) + 1;
    localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

    fetch_state_e    state_r;
    logic [XLEN-1:0] fetch_pc_r;
    logic [XLEN-1:0] rsp_pc_r;
    logic [CW-1:0]   outstanding_r;
    logic [CW-1:0]   discard_r;

    logic [CW:0]       credit_used_s;
    logic              req_valid_s;
    logic              req_fire_s;
    logic              rsp_take_s;
    logic              fifo_push_s;
    logic              fifo_pop_s;
    logic              fifo_flush_s;
    logic              fifo_empty_s;
    logic [CW-1:0]     fifo_count_s;
    logic [2*XLEN-1:0] fifo_rdata_s;
    logic [CW-1:0]     outstanding_nxt_s;

    // Handshake qualification and credit check. Outstanding requests plus
    // buffered entries never exceed DEPTH, so every response has a slot.
    always_comb begin
        credit_used_s = {1'b0, outstanding_r} + {1'b0, fifo_count_s};
        req_valid_s   = (state_r == ST_RUN) && !bus.redirect_valid
                        && (credit_used_s < (CW+1)'(DEPTH));
        req_fire_s    = req_valid_s && bus.imem_req_ready;
        // Responses outside a tracked request (e.g. left over from before a
        // reset) are ignored.
        rsp_take_s    = bus.imem_rsp_valid && (state_r != ST_IDLE)
                        && (outstanding_r != {CW{1'b0}});
        fifo_push_s   = rsp_take_s && (state_r == ST_RUN) && !bus.redirect_valid;
        fifo_pop_s    = !fifo_empty_s && bus.instr_ready;
        fifo_flush_s  = bus.redirect_valid && (state_r != ST_IDLE);
    end

    // Outstanding count after this cycle's accept and response.
    always_comb begin
        outstanding_nxt_s = outstanding_r;
        if (req_fire_s && !rsp_take_s) begin
            outstanding_nxt_s = outstanding_r + CW'(1);
        end else if (!req_fire_s && rsp_take_s) begin
            outstanding_nxt_s = outstanding_r - CW'(1);
        end else begin
            outstanding_nxt_s = outstanding_r;
        end
    end

    // Fetch FSM with PC, in-flight and discard bookkeeping.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_r       <= ST_IDLE;
            fetch_pc_r    <= RESET_PC;
            rsp_pc_r      <= RESET_PC;
            outstanding_r <= {CW{1'b0}};
            discard_r     <= {CW{1'b0}};
        end else begin
            outstanding_r <= outstanding_nxt_s;
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_RUN;
                end
                ST_RUN, ST_FLUSH: begin
                    if (bus.redirect_valid) begin
                        // Everything still in flight belongs to the old stream.
                        fetch_pc_r <= bus.redirect_pc;
                        rsp_pc_r   <= bus.redirect_pc;
                        discard_r  <= outstanding_nxt_s;
                        state_r    <= (outstanding_nxt_s != {CW{1'b0}}) ? ST_FLUSH : ST_RUN;
                    end else if (state_r == ST_RUN) begin
                        if (req_fire_s) begin
                            fetch_pc_r <= fetch_pc_r + STEP;
                        end
                        if (fifo_push_s) begin
                            rsp_pc_r <= rsp_pc_r + STEP;
                        end
                    end else if (rsp_take_s) begin
                        discard_r <= discard_r - CW'(1);
                        if (discard_r == CW'(1)) begin
                            state_r <= ST_RUN;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    philv_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rstb),
        .flush     (fifo_flush_s),
        .push      (fifo_push_s),
        .push_data ({rsp_pc_r, bus.imem_rsp_data}),
        .pop       (fifo_pop_s),
        .pop_data  (fifo_rdata_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    assign bus.imem_req_valid = req_valid_s;
    assign bus.imem_req_addr  = fetch_pc_r;
    assign bus.instr_valid    = !fifo_empty_s;
    assign bus.instr_data     = fifo_rdata_s[XLEN-1:0];
    assign bus.instr_pc       = fifo_rdata_s[2*XLEN-1:XLEN];

`ifdef PHILV_FETCH_PERF_EN
    // Saturating performance counters.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            perf_fetched <= 32'd0;
            perf_stall   <= 32'd0;
        end else begin
            if (req_fire_s && (perf_fetched != 32'hFFFF_FFFF)) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if ((state_r != ST_IDLE) && fifo_empty_s && (perf_stall != 32'hFFFF_FFFF)) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_philv_fetch_unit.sv
module tb_philv_fetch_unit;
    import philv_pkg::*;

    localparam int          XLEN  = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] KEY   = 32'hC0DE_5A5A;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstb_a;
    logic rstb_b;

    philv_fetch_unit_if #(.XLEN(XLEN)) bus_a ();
    philv_fetch_unit_if #(.XLEN(XLEN)) bus_b ();

`ifdef PHILV_FETCH_PERF_EN
    logic [31:0] pf_a, ps_a, pf_b, ps_b;
`endif

    philv_fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut_a (
        .clk  (clk),
        .rstb (rstb_a),
        .bus  (bus_a)
`ifdef PHILV_FETCH_PERF_EN
        , .perf_fetched (pf_a), .perf_stall (ps_a)
`endif
    );

    philv_fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0000_0080)) dut_b (
        .clk  (clk),
        .rstb (rstb_b),
        .bus  (bus_b)
`ifdef PHILV_FETCH_PERF_EN
        , .perf_fetched (pf_b), .perf_stall (ps_b)
`endif
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Memory models: one-cycle latency, responses held back while mem_hold_a.
    bit          mem_hold_a = 1'b0;
    int          rsp_cnt_a  = 0;
    logic [31:0] mq_a[$];
    logic [31:0] mq_b[$];

    always @(posedge clk or negedge rstb_a) begin
        if (!rstb_a) begin
            mq_a.delete();
            bus_a.imem_rsp_valid <= 1'b0;
            bus_a.imem_rsp_data  <= 32'd0;
        end else begin
            if (bus_a.imem_req_valid && bus_a.imem_req_ready) mq_a.push_back(bus_a.imem_req_addr);
            if (!mem_hold_a && mq_a.size() > 0) begin
                bus_a.imem_rsp_valid <= 1'b1;
                bus_a.imem_rsp_data  <= mq_a.pop_front() ^ KEY;
                rsp_cnt_a++;
            end else begin
                bus_a.imem_rsp_valid <= 1'b0;
            end
        end
    end

    always @(posedge clk or negedge rstb_b) begin
        if (!rstb_b) begin
            mq_b.delete();
            bus_b.imem_rsp_valid <= 1'b0;
            bus_b.imem_rsp_data  <= 32'd0;
        end else begin
            if (bus_b.imem_req_valid && bus_b.imem_req_ready) mq_b.push_back(bus_b.imem_req_addr);
            if (mq_b.size() > 0) begin
                bus_b.imem_rsp_valid <= 1'b1;
                bus_b.imem_rsp_data  <= mq_b.pop_front() ^ KEY;
            end else begin
                bus_b.imem_rsp_valid <= 1'b0;
            end
        end
    end

    // Scoreboard state for dut_a.
    logic [31:0] exp_q[$];
    logic [31:0] req_exp;
    logic [31:0] prev_addr;
    logic        prev_stall;
    logic        prev_redirect;
    int          cnt_pc8;

    typedef struct {
        int          ready_low;
        bit          hold;
        logic [31:0] exp_total;
        logic [31:0] exp_req_valid;
    } stall_vec_t;
    stall_vec_t stall_tbl[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic reload_sb(input logic [31:0] base);
        exp_q.delete();
        for (int i = 0; i < 512; i++) exp_q.push_back(base + 32'(i) * 32'd4);
    endtask

    // Observe dut_a just before the active edge.
    task automatic mon_a();
        logic [31:0] e;
        if (bus_a.imem_req_valid && bus_a.imem_req_ready) begin
            check("req_addr", bus_a.imem_req_addr, req_exp);
            req_exp = req_exp + 32'd4;
        end
        if (prev_stall && bus_a.imem_req_valid) check("req_addr_hold", bus_a.imem_req_addr, prev_addr);
        prev_stall = bus_a.imem_req_valid && !bus_a.imem_req_ready;
        prev_addr  = bus_a.imem_req_addr;
        if (prev_redirect) check("valid_after_redirect", 32'(bus_a.instr_valid), 32'd0);
        if (bus_a.instr_valid && bus_a.instr_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("instr_pc", bus_a.instr_pc, e);
                check("instr_data", bus_a.instr_data, e ^ KEY);
            end
            if (bus_a.instr_pc == 32'h8) cnt_pc8++;
        end
        if (bus_a.redirect_valid) begin
            reload_sb(bus_a.redirect_pc);
            req_exp = bus_a.redirect_pc;
        end
        prev_redirect = bus_a.redirect_valid;
    endtask

    task automatic tick();
        @(negedge clk);
        if (rstb_a) begin
            mon_a();
        end else begin
            reload_sb(32'h0);
            req_exp       = 32'h0;
            prev_stall    = 1'b0;
            prev_redirect = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_a(input logic [31:0] pc);
        bus_a.redirect_valid = 1'b1;
        bus_a.redirect_pc    = pc;
        tick();
        bus_a.redirect_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int snap;
        stall_tbl[0] = '{ready_low: 10, hold: 1'b0, exp_total: 32'd4, exp_req_valid: 32'd0};
        stall_tbl[1] = '{ready_low: 10, hold: 1'b1, exp_total: 32'd4, exp_req_valid: 32'd0};
        stall_tbl[2] = '{ready_low: 6,  hold: 1'b0, exp_total: 32'd4, exp_req_valid: 32'd0};
        cnt_pc8 = 0;
        rstb_a = 1'b0;
        rstb_b = 1'b0;
        bus_a.imem_req_ready = 1'b1; bus_a.redirect_valid = 1'b0;
        bus_a.redirect_pc = 32'h0;   bus_a.instr_ready = 1'b1;
        bus_b.imem_req_ready = 1'b1; bus_b.redirect_valid = 1'b0;
        bus_b.redirect_pc = 32'h0;   bus_b.instr_ready = 1'b1;
        repeat (3) tick();

        // Reset state
        check("rst_req_valid", 32'(bus_a.imem_req_valid), 32'd0);
        check("rst_instr_valid", 32'(bus_a.instr_valid), 32'd0);
        check("rst_instr_data", bus_a.instr_data, 32'd0);
        check("rst_instr_pc", bus_a.instr_pc, 32'd0);
        check("rst_state", 32'(dut_a.state_r), 32'(ST_IDLE));
        check("rst_b_instr_pc", bus_b.instr_pc, 32'd0);

        // Release: one IDLE cycle, then RUN with first request at RESET_PC
        rstb_a = 1'b1;
        rstb_b = 1'b1;
        tick();
        check("run_after_idle", 32'(dut_a.state_r), 32'(ST_RUN));
        check("first_req_valid", 32'(bus_a.imem_req_valid), 32'd1);
        check("first_req_addr", bus_a.imem_req_addr, 32'h0);

        // Streaming: one instruction per cycle once the pipe is full
        n = 0;
        while (!bus_a.instr_valid && n < 20) begin tick(); n++; end
        check("stream_start", 32'(bus_a.instr_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stream_valid", 32'(bus_a.instr_valid), 32'd1);
        end

        // Request back-pressure: address must hold
        bus_a.imem_req_ready = 1'b0;
        repeat (3) tick();
        bus_a.imem_req_ready = 1'b1;
        repeat (6) tick();

        // Decode stall table
        for (int v = 0; v < 3; v++) begin
            bus_a.instr_ready = 1'b0;
            mem_hold_a = stall_tbl[v].hold;
            repeat (stall_tbl[v].ready_low) tick();
            check("stall_total", 32'(dut_a.outstanding_r) + 32'(dut_a.fifo_count_s), stall_tbl[v].exp_total);
            check("stall_req_valid", 32'(bus_a.imem_req_valid), stall_tbl[v].exp_req_valid);
            mem_hold_a = 1'b0;
            bus_a.instr_ready = 1'b1;
            repeat (8) tick();
        end

        // Redirect to 0x100 with 3 outstanding
        mem_hold_a = 1'b1;
        n = 0;
        while (!(dut_a.outstanding_r == 3 && !bus_a.imem_rsp_valid) && n < 30) begin tick(); n++; end
        check("out3_reached", 32'(dut_a.outstanding_r), 32'd3);
        redirect_a(32'h100);
        check("flush_entered", 32'(dut_a.state_r), 32'(ST_FLUSH));
        check("flush_discard", 32'(dut_a.discard_r), 32'd3);
        snap = rsp_cnt_a;
        mem_hold_a = 1'b0;
        n = 0;
        while (dut_a.state_r != ST_RUN && n < 20) begin tick(); n++; end
        check("flush_to_run", 32'(dut_a.state_r), 32'(ST_RUN));
        check("dropped_rsp", 32'(rsp_cnt_a - snap), 32'd3);
        n = 0;
        while (!bus_a.instr_valid && n < 20) begin tick(); n++; end
        check("after_flush_pc", bus_a.instr_pc, 32'h100);
        repeat (5) tick();

        // Redirect coincident with decode of 0x8
        snap = cnt_pc8;
        redirect_a(32'h0);
        n = 0;
        while (!(bus_a.instr_valid && bus_a.instr_pc == 32'h8) && n < 30) begin tick(); n++; end
        check("pc8_at_head", bus_a.instr_pc, 32'h8);
        redirect_a(32'h300);
        n = 0;
        while (!bus_a.instr_valid && n < 20) begin tick(); n++; end
        check("coincident_next_pc", bus_a.instr_pc, 32'h300);
        repeat (15) tick();
        check("pc8_once", 32'(cnt_pc8 - snap), 32'd1);

        // Second redirect during FLUSH
        mem_hold_a = 1'b1;
        n = 0;
        while (!(dut_a.outstanding_r == 2 && !bus_a.imem_rsp_valid) && n < 30) begin tick(); n++; end
        redirect_a(32'h180);
        check("flush1_state", 32'(dut_a.state_r), 32'(ST_FLUSH));
        tick();
        redirect_a(32'h200);
        check("flush2_state", 32'(dut_a.state_r), 32'(ST_FLUSH));
        check("flush2_discard", 32'(dut_a.discard_r), 32'd2);
        mem_hold_a = 1'b0;
        n = 0;
        while (!bus_a.instr_valid && n < 30) begin tick(); n++; end
        check("second_redirect_pc", bus_a.instr_pc, 32'h200);
        repeat (10) tick();

        // Asynchronous reset of dut_b mid-fetch, RESET_PC = 0x80
        check("b_mid_fetch_valid", 32'(bus_b.instr_valid), 32'd1);
        #2 rstb_b = 1'b0;
        #1;
        check("b_rst_req_valid", 32'(bus_b.imem_req_valid), 32'd0);
        check("b_rst_instr_valid", 32'(bus_b.instr_valid), 32'd0);
        check("b_rst_instr_data", bus_b.instr_data, 32'd0);
        check("b_rst_instr_pc", bus_b.instr_pc, 32'd0);
        repeat (2) tick();
        rstb_b = 1'b1;
        n = 0;
        while (!bus_b.imem_req_valid && n < 10) begin tick(); n++; end
        check("b_first_req_addr", bus_b.imem_req_addr, 32'h80);
        n = 0;
        while (!bus_b.instr_valid && n < 10) begin tick(); n++; end
        check("b_first_instr_pc", bus_b.instr_pc, 32'h80);
        check("b_first_instr_data", bus_b.instr_data, 32'h80 ^ KEY);
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
